avr_dmem_arbiter: RTL

//  Shares the AVR core's single-port synchronous data SRAM between two requesters:

---
 rtl/avr_dmem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/avr_dmem_arbiter.sv
// Data-memory arbiter for the AVR core: shares one synchronous SRAM port between
// the core (fixed priority, optional lock) and the host (starvation-protected).
module avr_dmem_arbiter #(
    parameter int AW       = 11,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic          c_lock,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_H    = 2'd2
    } owner_t;

    logic [3:0]    wait_cnt;
    logic          locked;
    owner_t        rd_owner;
    logic [DW-1:0] c_hold;
    logic [DW-1:0] h_hold;
    logic          lock_eff;

    // Lock releases in the very cycle c_lock drops, so that cycle arbitrates normally.
    assign lock_eff = locked & c_lock;

    always_comb begin
        c_gnt = 1'b0;
        h_gnt = 1'b0;
        if (!reset) begin
            if (lock_eff) begin
                c_gnt = c_req;
            end else if (wait_cnt == WAIT_MAX) begin
                if (h_req) h_gnt = 1'b1;
                else       c_gnt = c_req;
            end else if (c_req) begin
                c_gnt = 1'b1;
            end else begin
                h_gnt = h_req;
            end
        end
    end

    always_comb begin
        mem_en    = c_gnt | h_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_gnt) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (h_gnt) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            locked   <= 1'b0;
            rd_owner <= OWN_NONE;
            c_hold   <= '0;
            h_hold   <= '0;
        end else begin
            if (h_req && !h_gnt) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end

            if (!c_lock)    locked <= 1'b0;
            else if (c_gnt) locked <= 1'b1;

            if (c_gnt && !c_we)      rd_owner <= OWN_C;
            else if (h_gnt && !h_we) rd_owner <= OWN_H;
            else                     rd_owner <= OWN_NONE;

            if (rd_owner == OWN_C) c_hold <= mem_rdata;
            if (rd_owner == OWN_H) h_hold <= mem_rdata;
        end
    end

    // Read data is live from the SRAM for the owner; the other port keeps its last word.
    assign c_rvalid = (rd_owner == OWN_C) && !reset;
    assign h_rvalid = (rd_owner == OWN_H) && !reset;
    assign c_rdata  = (rd_owner == OWN_C) ? mem_rdata : c_hold;
    assign h_rdata  = (rd_owner == OWN_H) ? mem_rdata : h_hold;

endmodule
